// File: rtl/mod_pow2_mul_seq.sv
// Sequential modular multiply by 2^k: oData = (iData << iShift) mod iMod, one doubling per cycle.
// Optional range check on accept is enabled by defining MOD_POW2_MUL_RANGE_CHECK_EN.
module mod_pow2_mul_seq #(
  parameter int BITWIDTH = 32,
  parameter int SHIFTW   = 5
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [SHIFTW-1:0] CNT_ONE = {{(SHIFTW-1){1'b0}}, 1'b1};

  state_t              state;
  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] mod_r;
  logic [SHIFTW-1:0]   cnt;

  logic                accept;
  logic                range_bad;
  logic [BITWIDTH:0]   dbl;
  logic [BITWIDTH:0]   dbl_sub;
  logic [BITWIDTH-1:0] acc_nxt;

  assign oReady = (state == S_IDLE) |
                  ((state == S_DONE) & iReady);
  assign accept = iValid & oReady;

`ifdef MOD_POW2_MUL_RANGE_CHECK_EN
  assign range_bad = (iMod == '0) | (iData >= iMod);
`else
  assign range_bad = 1'b0;
`endif

  // acc < mod is invariant, so one conditional subtract keeps 2*acc reduced
  assign dbl     = {acc, 1'b0};
  assign dbl_sub = dbl - {1'b0, mod_r};
  assign acc_nxt = (dbl >= {1'b0, mod_r}) ?
                   dbl_sub[BITWIDTH-1:0] :
                   dbl[BITWIDTH-1:0];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mod_r  <= '0;
      cnt    <= '0;
      oValid <= 1'b0;
      oData  <= '0;
      oErr   <= 1'b0;
    end else if (iClr) begin
      state  <= S_IDLE;
      acc    <= '0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= S_DONE;
            oValid <= 1'b1;
            oData  <= acc_nxt;
          end
        end
        S_DONE: begin
          if (iReady) begin
            state  <= S_IDLE;
            oValid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // a load overrides the DONE->IDLE step for back-to-back requests
      if (accept) begin
        acc   <= iData;
        mod_r <= iMod;
        cnt   <= iShift;
        oErr  <= 1'b0;
        if (range_bad) begin
          acc    <= '0;
          cnt    <= '0;
          state  <= S_DONE;
          oValid <= 1'b1;
          oData  <= '0;
          oErr   <= 1'b1;
        end else if (iShift == '0) begin
          state  <= S_DONE;
          oValid <= 1'b1;
          oData  <= iData;
        end else begin
          state  <= S_RUN;
          oValid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_pow2_mul_seq.sv
// Bench for mod_pow2_mul_seq: directed boundary cases plus random requests
// against an arithmetic reference (d * 2^k) mod m.
module tb_mod_pow2_mul_seq;

  localparam int W  = 8;
  localparam int SW = 5;

`ifdef MOD_POW2_MUL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iClr;
  logic          iValid;
  logic          oReady;
  logic [W-1:0]  iData;
  logic [W-1:0]  iMod;
  logic [SW-1:0] iShift;
  logic          oValid;
  logic          iReady;
  logic [W-1:0]  oData;
  logic          oErr;

  int checks   = 0;
  int failures = 0;

  mod_pow2_mul_seq #(
    .BITWIDTH(W),
    .SHIFTW  (SW)
  ) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iClr  (iClr),
    .iValid(iValid),
    .oReady(oReady),
    .iData (iData),
    .iMod  (iMod),
    .iShift(iShift),
    .oValid(oValid),
    .iReady(iReady),
    .oData (oData),
    .oErr  (oErr)
  );

  always #5 iClk = ~iClk;

  function automatic logic [63:0] model(input int unsigned d,
                                        input int unsigned m,
                                        input int unsigned k);
    longint unsigned p;
    p = longint'(d) << k;
    return 64'(p % longint'(m));
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present a request and return #1 after the accepting edge
  task automatic send(input int unsigned d,
                      input int unsigned m,
                      input int unsigned k);
    int n;
    @(negedge iClk);
    iValid = 1'b1;
    iData  = W'(d);
    iMod   = W'(m);
    iShift = SW'(k);
    n = 0;
    while (!oReady && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("send_ready", {63'd0, oReady}, 64'd1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iData  = W'($urandom);
    iMod   = W'($urandom);
    iShift = SW'($urandom);
  endtask

  task automatic wait_result(input string tag,
                             input int lat,
                             input logic [63:0] exp_d,
                             input logic exp_err,
                             input bit chk_d,
                             input bit noise);
    int n;
    n = 0;
    while (!oValid && n < 100) begin
      check({tag, "_busy"}, {63'd0, oReady}, 64'd0);
      if (noise) begin
        iValid = 1'b1;
        iData  = W'($urandom);
        iMod   = W'($urandom);
        iShift = SW'($urandom);
      end
      @(posedge iClk);
      #1;
      n++;
    end
    iValid = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(lat));
    if (chk_d) check({tag, "_data"}, 64'(oData), exp_d);
    check({tag, "_err"}, {63'd0, oErr}, {63'd0, exp_err});
  endtask

  task automatic consume();
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    check("consume_valid", {63'd0, oValid}, 64'd0);
    check("consume_ready", {63'd0, oReady}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] saved;
    int unsigned  m, d, k;
    bit           nz;

    iRst   = 1'b1;
    iClr   = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iData  = '0;
    iMod   = '0;
    iShift = '0;
    #1;
    check("rst_valid", {63'd0, oValid}, 64'd0);
    check("rst_data",  64'(oData), 64'd0);
    check("rst_err",   {63'd0, oErr}, 64'd0);
    check("rst_ready", {63'd0, oReady}, 64'd1);
    #12;
    @(negedge iClk);
    iRst = 1'b0;

    // worked examples
    send(7, 13, 3);
    wait_result("ex13", 3, 64'd4, 1'b0, 1'b1, 1'b0);
    consume();
    send(254, 255, 7);
    wait_result("ex255", 7, 64'd127, 1'b0, 1'b1, 1'b1);
    consume();
    send(5, 13, 0);
    wait_result("k0", 0, 64'd5, 1'b0, 1'b1, 1'b0);
    consume();
    send(0, 1, 9);
    wait_result("mod1", 9, 64'd0, 1'b0, 1'b1, 1'b0);
    consume();
    send(200, 251, 31);
    wait_result("kmax", 31, model(200, 251, 31), 1'b0, 1'b1, 1'b1);

    // result held under backpressure, then back-to-back accept
    saved = oData;
    repeat (5) begin
      @(negedge iClk);
      check("hold_valid", {63'd0, oValid}, 64'd1);
      check("hold_data",  64'(oData), 64'(saved));
      check("hold_ready", {63'd0, oReady}, 64'd0);
    end
    @(negedge iClk);
    iReady = 1'b1;
    iValid = 1'b1;
    iData  = 8'd9;
    iMod   = 8'd23;
    iShift = 5'd2;
    #1;
    check("b2b_ready", {63'd0, oReady}, 64'd1);
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    iValid = 1'b0;
    wait_result("b2b", 2, model(9, 23, 2), 1'b0, 1'b1, 1'b0);
    consume();

    // synchronous clear mid-run
    saved = oData;
    send(100, 251, 6);
    @(posedge iClk);
    @(negedge iClk);
    iClr = 1'b1;
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    check("clr_valid", {63'd0, oValid}, 64'd0);
    check("clr_ready", {63'd0, oReady}, 64'd1);
    check("clr_data",  64'(oData), 64'(saved));
    send(100, 251, 6);
    wait_result("after_clr", 6, model(100, 251, 6), 1'b0, 1'b1, 1'b0);
    consume();

    // asynchronous reset mid-run
    send(3, 200, 10);
    @(posedge iClk);
    @(posedge iClk);
    #3;
    iRst = 1'b1;
    #1;
    check("arst_valid", {63'd0, oValid}, 64'd0);
    check("arst_data",  64'(oData), 64'd0);
    check("arst_err",   {63'd0, oErr}, 64'd0);
    check("arst_ready", {63'd0, oReady}, 64'd1);
    @(negedge iClk);
    iRst = 1'b0;
    send(3, 200, 10);
    wait_result("after_rst", 10, model(3, 200, 10), 1'b0, 1'b1, 1'b0);
    consume();

    // out-of-range operands
    send(20, 13, 2);
    wait_result("rng_data", RC ? 0 : 2, 64'd0, RC, RC, 1'b0);
    consume();
    send(4, 0, 2);
    wait_result("rng_mod0", RC ? 0 : 2, 64'd0, RC, RC, 1'b0);
    consume();
    send(6, 11, 1);
    wait_result("rng_clear", 1, 64'd1, 1'b0, 1'b1, 1'b0);
    consume();

    // random requests against the reference
    for (int i = 0; i < 25; i++) begin
      m  = $urandom_range(1, 255);
      d  = $urandom_range(0, m - 1);
      k  = $urandom_range(0, 31);
      nz = 1'($urandom_range(0, 1));
      send(d, m, k);
      wait_result("rand", int'(k), model(d, m, k), 1'b0, 1'b1, nz);
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
